// File: rtl/rv32i_types_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types_pkg
//   Scalar base types shared by the integer pipeline and the vector unit.
//   word_t is the architectural register / memory word (XLEN bits).
// -----------------------------------------------------------------------------
package rv32i_types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

endpackage : rv32i_types_pkg

// File: rtl/rv32v_types_pkg.sv
// -----------------------------------------------------------------------------
// rv32v_types_pkg
//   Vector-unit types: lane count per uop, element-width encoding and the
//   load-collector FSM state enum.
// -----------------------------------------------------------------------------
package rv32v_types_pkg;

  import rv32i_types_pkg::*;

  // Vector lanes carried by one uop.
  localparam int NUM_LANES = 4;

  // Selected element width. SEW64 is not supported by this RV32 datapath.
  // Consumers treat it like SEW32 (the full word is passed through).
  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } vsew_t;

  // Load collector FSM.
  //   IDLE    : waiting for a vector load uop
  //   COLLECT : gathering per-lane load data from the LSC
  //   WB      : assembled result presented to writeback
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WB      = 2'b10
  } collector_state_t;

endpackage : rv32v_types_pkg

// File: rtl/rv32v_load_extend.sv
// -----------------------------------------------------------------------------
// rv32v_load_extend
//   Extracts one element from a raw LSC load word and zero-extends it to a
//   full word according to the element width.
//
// Ports
//   eew  in   element width of the uop being collected
//   raw  in   load word returned by the LSC
//   ext  out  zero-extended element (SEW8 -> [7:0], SEW16 -> [15:0],
//             SEW32 -> [31:0])
// -----------------------------------------------------------------------------
module rv32v_load_extend
  import rv32i_types_pkg::*;
  import rv32v_types_pkg::*;
(
  input  vsew_t eew,
  input  word_t raw,
  output word_t ext
);

  always_comb begin
    ext = raw;
    case (eew)
      SEW8:    ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      SEW16:   ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule : rv32v_load_extend

// File: rtl/rv32v_load_collector.sv
// -----------------------------------------------------------------------------
// rv32v_load_collector
//   Gathers the per-lane results of one vector load uop as the LSC returns
//   them (in any order), merges masked lanes with the old destination
//   contents (mask-undisturbed) and presents the assembled uop to writeback.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   vstart_ld        pulse: new uop; samples vlane_mask/veew/vuop_num/vd/
//                    vold_data. Accepted in IDLE, or in WB together with
//                    wb_ready (back-to-back); ignored otherwise.
//   vlane_mask       1 = lane active, 0 = masked
//   veew             element width of the uop
//   vuop_num, vd     uop index / destination register (passed to writeback)
//   vold_data        previous vd contents, used for masked lanes
//   lsc_ready        one lane's load data valid this cycle (COLLECT only)
//   vcurr_lane       lane index of the returned data
//   vload_data       raw load data
//   flush            abort the in-flight uop; overrides every other input
//   wb_ready         writeback accepts the presented result
//   busy             FSM is in COLLECT or WB
//   wb_valid         assembled result valid
//   wb_data          per-lane result
//   wb_vd, wb_uop_num, wb_mask   latched uop attributes
//   state_dbg        current FSM state for observation
//
// Writeback handshake: wb_valid/wb_data/wb_vd/wb_uop_num/wb_mask are held
// stable from the cycle wb_valid rises until the cycle wb_ready is seen high
// while wb_valid is high; the transfer completes on that rising edge.
// -----------------------------------------------------------------------------
module rv32v_load_collector
  import rv32i_types_pkg::*;
  import rv32v_types_pkg::*;
#(
  parameter  int NUM_LANES = rv32v_types_pkg::NUM_LANES,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vstart_ld,
  input  logic [NUM_LANES-1:0]   vlane_mask,
  input  vsew_t                  veew,
  input  logic [4:0]             vuop_num,
  input  logic [4:0]             vd,
  input  word_t [NUM_LANES-1:0]  vold_data,
  input  logic                   lsc_ready,
  input  logic [LANE_W-1:0]      vcurr_lane,
  input  word_t                  vload_data,
  input  logic                   flush,
  input  logic                   wb_ready,
  output logic                   busy,
  output logic                   wb_valid,
  output word_t [NUM_LANES-1:0]  wb_data,
  output logic [4:0]             wb_vd,
  output logic [4:0]             wb_uop_num,
  output logic [NUM_LANES-1:0]   wb_mask,
  output collector_state_t       state_dbg
);

  collector_state_t       state_q, state_d;
  logic [NUM_LANES-1:0]   rcvd_q, rcvd_d;
  logic [NUM_LANES-1:0]   mask_q;
  vsew_t                  eew_q;
  logic [4:0]             vd_q;
  logic [4:0]             uop_q;
  word_t [NUM_LANES-1:0]  data_q;

  logic                   accept_uop;
  logic                   lane_wr;
  word_t                  lane_ext;

  // Single extraction path: the element width is the latched one, so the
  // extender only ever sees the width of the uop currently being collected.
  rv32v_load_extend u_extend (
    .eew (eew_q),
    .raw (vload_data),
    .ext (lane_ext)
  );

  // Next state, received-bit update and the two datapath strobes.
  always_comb begin
    state_d    = state_q;
    rcvd_d     = rcvd_q;
    accept_uop = 1'b0;
    lane_wr    = 1'b0;

    if (flush) begin
      state_d = IDLE;
      rcvd_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vstart_ld) begin
            accept_uop = 1'b1;
          end
        end

        COLLECT: begin
          // Only the first return for an active lane is taken; repeats and
          // returns for masked lanes leave all state untouched.
          if (lsc_ready && mask_q[vcurr_lane] && !rcvd_q[vcurr_lane]) begin
            lane_wr            = 1'b1;
            rcvd_d[vcurr_lane] = 1'b1;
          end
          if (&(rcvd_d | ~mask_q)) begin
            state_d = WB;
          end
        end

        WB: begin
          if (wb_ready) begin
            state_d = IDLE;
            rcvd_d  = '0;
            if (vstart_ld) begin
              accept_uop = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          rcvd_d  = '0;
        end
      endcase
    end

    // A fully masked uop has nothing to collect and goes straight to WB.
    if (accept_uop) begin
      rcvd_d  = '0;
      state_d = (vlane_mask == '0) ? WB : COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcvd_q  <= '0;
      mask_q  <= '0;
      eew_q   <= SEW8;
      vd_q    <= '0;
      uop_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rcvd_q  <= rcvd_d;
      if (accept_uop) begin
        // Preload every lane with the old contents; active lanes are
        // overwritten as their data arrives, masked lanes keep it.
        mask_q <= vlane_mask;
        eew_q  <= veew;
        vd_q   <= vd;
        uop_q  <= vuop_num;
        data_q <= vold_data;
      end else if (lane_wr) begin
        data_q[vcurr_lane] <= lane_ext;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign wb_valid   = (state_q == WB);
  assign wb_data    = data_q;
  assign wb_vd      = vd_q;
  assign wb_uop_num = uop_q;
  assign wb_mask    = mask_q;
  assign state_dbg  = state_q;

endmodule : rv32v_load_collector
